// File: rtl/ram_stream_reader_pkg.sv
// Shared constants for the RAM burst stream reader.
// FSM state codes, FIFO depth and pointer helper.
package ram_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int FIFO_DEPTH = 3;

  typedef logic [1:0] fifo_ptr_t;

  function automatic fifo_ptr_t ptr_inc(
    input fifo_ptr_t p
  );
    if (p == fifo_ptr_t'(FIFO_DEPTH - 1))
      return '0;
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Burst request, RAM read port and output stream bundle.
// master drives requests/RAM data/ready; slave is the reader.
interface ram_stream_reader_if #(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048
);
  logic              start;
  logic [BDADDR-1:0] base_addr;
  logic [BDADDR:0]   length;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [BDADDR-1:0] rd_addr;
  logic [BDWORD-1:0] rd_word;
  logic              o_valid;
  logic              o_ready;
  logic [BDWORD-1:0] o_word;
  logic              o_last;

  modport master (
    output start, base_addr, length,
    output rd_word, o_ready,
    input  busy, done, rd_en, rd_addr,
    input  o_valid, o_word, o_last
  );

  modport slave (
    input  start, base_addr, length,
    input  rd_word, o_ready,
    output busy, done, rd_en, rd_addr,
    output o_valid, o_word, o_last
  );
endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Three-entry FIFO catching RAM read data.
// Ports: clk, rst, push/din, pop/dout, count.
module ram_rd_skid_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int W = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  fifo_ptr_t    wp;
  fifo_ptr_t    rp;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push &&
    ((count != 2'(FIFO_DEPTH)) || do_pop);

  // Empty FIFO shows zero so stale data never leaks.
  assign dout = (count != 2'd0) ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= ptr_inc(wp);
      if (do_pop)  rp <= ptr_inc(rp);
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of RAM words and streams them out.
// Ports: clk, rst, bus (slave: request, RAM port, stream).
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048
) (
  input logic               clk,
  input logic               rst,
  ram_stream_reader_if.slave bus
);

  localparam logic [BDADDR:0] ONE = 1;

  logic [1:0]        state;
  logic [BDADDR-1:0] base_q;
  logic [BDADDR:0]   len_q;
  logic [BDADDR:0]   iss;
  logic [BDADDR:0]   out_idx;
  logic              inflight;
  logic              done_q;
  logic [1:0]        fcount;
  logic [BDWORD-1:0] head;
  logic              can_rd;
  logic              last_rd;
  logic              pop;

  // Credit check: buffered plus in-flight words
  // must leave room for one more read.
  assign can_rd =
    ({1'b0, fcount} + {2'b00, inflight})
    < 3'(FIFO_DEPTH);

  assign bus.rd_en   = (state == ST_RUN) && can_rd;
  assign bus.rd_addr = base_q + iss[BDADDR-1:0];
  assign last_rd     = (iss == len_q - ONE);

  assign bus.o_valid = (fcount != 2'd0);
  assign bus.o_word  = head;
  assign bus.o_last  = bus.o_valid &&
                       (out_idx == len_q - ONE);
  assign pop         = bus.o_valid && bus.o_ready;

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;

  ram_rd_skid_fifo #(
    .W(BDWORD)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (bus.rd_word),
    .pop  (pop),
    .dout (head),
    .count(fcount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      iss      <= '0;
      out_idx  <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= bus.rd_en;
      done_q   <= 1'b0;
      if (bus.rd_en) iss <= iss + ONE;
      if (pop) out_idx <= out_idx + ONE;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (bus.start) begin
            base_q  <= bus.base_addr;
            len_q   <= bus.length;
            iss     <= '0;
            out_idx <= '0;
            state   <= (bus.length == '0)
                       ? ST_DRAIN : ST_RUN;
          end
        end
        (state == ST_RUN): begin
          if (bus.rd_en && last_rd)
            state <= ST_DRAIN;
        end
        (state == ST_DRAIN): begin
          if (fcount == 2'd0 && !inflight) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter BDADDR, default 12, RAM address width in bits.
REQ-002 Parameter BDWORD, default 2048, RAM word width in bits.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  in  BDADDR  first RAM address of the burst; captured with start.
REQ-008 length  in  BDADDR+1  word count, 0..2**BDADDR; captured with start.
REQ-009 busy  out  1  high from the cycle after start is accepted until done.
REQ-010 done  out  1  one-cycle pulse marking burst completion.
REQ-011 rd_en  out  1  RAM read enable.
REQ-012 rd_addr  out  BDADDR  RAM read address.
REQ-013 rd_word  in  BDWORD  RAM read data; valid the cycle after rd_en, zero otherwise.
REQ-014 o_valid  out  1  stream word available.
REQ-015 o_ready  in  1  downstream accepts word when o_valid&o_ready.
REQ-016 o_word  out  BDWORD  stream data.
REQ-017 o_last  out  1  high with the final word of the burst.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN, encoded per the shared package.
REQ-019 IDLE -> RUN when start=1 and length>0; IDLE -> DRAIN when start=1 and length=0; start SHALL be ignored outside IDLE.
REQ-020 RUN SHALL issue rd_en=1 with rd_addr=base_addr+i for i=0..length-1, in order, addresses wrapping modulo 2**BDADDR.
REQ-021 A read SHALL issue in a cycle only if (fifo_count + inflight) < 3 at cycle start; inflight=1 iff rd_en was high the previous cycle.
REQ-022 rd_word SHALL be captured into a 3-entry FIFO in the cycle after each rd_en; it SHALL never be sampled otherwise.
REQ-023 RUN -> DRAIN after the last read issues; DRAIN -> IDLE when the FIFO is empty and inflight=0 after the last word is accepted.
REQ-024 done SHALL pulse for one cycle on the cycle after the transition to IDLE; for length=0 done pulses two cycles after start, with no rd_en and no o_valid.
REQ-025 Latency: start accepted at cycle T -> first rd_en at T+1 -> o_valid at T+3.
REQ-026 With o_ready held high, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-027 o_valid/o_word/o_last SHALL hold stable while o_valid=1 and o_ready=0.
REQ-028 o_last SHALL be high only with word index length-1.
REQ-029 rd_en SHALL be low in IDLE and DRAIN; rd_addr is don't-care when rd_en=0 but SHALL NOT be X.

Reset
REQ-030 rst=1 SHALL return the block to IDLE within one cycle, aborting any burst mid-operation and discarding FIFO contents and inflight data.
REQ-031 Reset values: busy=0, done=0, rd_en=0, rd_addr=0, o_valid=0, o_last=0, o_word=0.
REQ-032 No done pulse SHALL be generated for an aborted burst.

Structure
REQ-033 State encoding and FIFO depth constant (3) SHALL live in the shared package/header.
REQ-034 The FIFO SHALL be one sub-module, ram_rd_skid_fifo (depth 3, width BDWORD, count output, same clock/reset).

Verification
REQ-035 base_addr=0x010, length=4, o_ready=1 -> rd_addr 0x010..0x013 on T+1..T+4; o_word = mem[0x010..0x013] on T+3..T+6; o_last at T+6; done at T+8.
REQ-036 base_addr=0xFFE, length=4 -> rd_addr 0xFFE,0xFFF,0x000,0x001.
REQ-037 length=8, o_ready toggling 1,0,0,1,... -> all 8 words in order, no loss or duplication, (fifo_count+inflight) never exceeds 3.
REQ-038 length=0 -> no rd_en, no o_valid, done pulses at T+2.
REQ-039 rst asserted mid-burst (word 2 of 6 pending) -> next cycle all outputs at reset values; a new start then runs a clean burst.
REQ-040 start asserted while busy -> ignored; running burst completes unchanged.
